// File: rtl/muldiv_iter.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with sign fix-up and divide-by-zero detection.
module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_div_zero,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_is_div;
  logic             r_sa;
  logic             r_sb;
  logic             r_dz;
  logic [WIDTH:0]   r_p;
  logic [WIDTH-1:0] r_m;
  logic [WIDTH-1:0] r_b;

  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_mul_p;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_sub;
  logic             w_ge;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0] w_quo;
  logic [WIDTH-1:0] w_rem;

  // Signs only matter for the signed ops (op[0] == 0).
  assign w_a_neg = i_a[WIDTH-1] & ~i_op[0];
  assign w_b_neg = i_b[WIDTH-1] & ~i_op[0];
  assign w_a_mag = w_a_neg ? -i_a : i_a;
  assign w_b_mag = w_b_neg ? -i_b : i_b;

  // Multiply: r_p is the high half of {P, multiplier}; r_b holds the multiplicand.
  assign w_add   = r_p + {1'b0, r_b};
  assign w_mul_p = r_m[0] ? w_add : r_p;

  // Divide: r_p is the partial remainder, r_m shifts dividend out and quotient in.
  assign w_shift = {r_p[WIDTH-1:0], r_m[WIDTH-1]};
  assign w_ge    = (w_shift >= {1'b0, r_b});
  assign w_sub   = w_shift - {1'b0, r_b};

  assign w_prod     = {r_p[WIDTH-1:0], r_m};
  assign w_prod_fix = (r_sa ^ r_sb) ? -w_prod : w_prod;
  assign w_quo      = (r_sa ^ r_sb) ? -r_m : r_m;
  assign w_rem      = r_sa ? -r_p[WIDTH-1:0] : r_p[WIDTH-1:0];

  // A divide-by-zero skips BUSY and goes through FIX without touching hi/lo.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_is_div   <= 1'b0;
      r_sa       <= 1'b0;
      r_sb       <= 1'b0;
      r_dz       <= 1'b0;
      r_p        <= '0;
      r_m        <= '0;
      r_b        <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_div_zero <= 1'b0;
      o_hi       <= '0;
      o_lo       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_is_div <= i_op[1];
            r_sa     <= w_a_neg;
            r_sb     <= w_b_neg;
            r_p      <= '0;
            r_cnt    <= CNT_INIT;
            o_busy   <= 1'b1;
            if (i_op[1]) begin
              r_m <= w_a_mag;
              r_b <= w_b_mag;
            end else begin
              r_m <= w_b_mag;
              r_b <= w_a_mag;
            end
            if (i_op[1] && (i_b == '0)) begin
              r_dz    <= 1'b1;
              r_state <= S_FIX;
            end else begin
              r_state <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_is_div) begin
            r_p <= w_ge ? w_sub : w_shift;
            r_m <= {r_m[WIDTH-2:0], w_ge};
          end else begin
            r_p <= {1'b0, w_mul_p[WIDTH:1]};
            r_m <= {w_mul_p[0], r_m[WIDTH-1:1]};
          end
          if (r_cnt == CW'(1)) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          o_done  <= 1'b1;
          r_state <= S_DONE;
          if (r_dz) begin
            o_div_zero <= 1'b1;
          end else if (r_is_div) begin
            o_hi <= w_rem;
            o_lo <= w_quo;
          end else begin
            o_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
            o_lo <= w_prod_fix[WIDTH-1:0];
          end
        end
        default: begin
          o_done     <= 1'b0;
          o_div_zero <= 1'b0;
          o_busy     <= 1'b0;
          r_dz       <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule
